// File: rtl/jbooth_pkg.sv
// Shared types and sizing helpers for the sequential radix-2 Booth multiplier.
package jbooth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter must hold 0..WIDTH, sized with one spare code.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/jbooth_step.sv
// One radix-2 Booth step: recode {Q0,q_1}, add/subtract A_ext into P, then
// arithmetic-shift the whole {P,Q,q_1} accumulator right by one.
module jbooth_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0] p,
  input  logic [WIDTH:0] q,
  input  logic           q_1,
  input  logic [WIDTH:0] a_ext,
  output logic [WIDTH:0] p_nxt,
  output logic [WIDTH:0] q_nxt,
  output logic           q_1_nxt
);

  logic [WIDTH+1:0] p_wide;
  logic [WIDTH+1:0] sum;

  // One guard bit on the add/subtract; after the shift the top two bits of
  // sum are always equal, so dropping one of them loses nothing.
  always_comb begin
    // NOTE: every comb output gets a value on every path, otherwise a latch is inferred.
    p_wide = {p[WIDTH], p};
    sum    = p_wide;
    unique case ({q[0], q_1})
      2'b01:   sum = p_wide + {a_ext[WIDTH], a_ext};
      2'b10:   sum = p_wide - {a_ext[WIDTH], a_ext};
      default: sum = p_wide;
    endcase
    p_nxt   = sum[WIDTH+1:1];
    q_nxt   = {sum[0], q[WIDTH:1]};
    q_1_nxt = q[0];
  end

endmodule

// File: rtl/jbooth_multiplier.sv
// Start/done sequential Booth multiplier, unsigned or two's-complement per
// operation; one Booth step per clock, WIDTH+1 steps per product.
module jbooth_multiplier
  import jbooth_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y,
  output logic               busy,
  output logic               done
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [WIDTH:0]  a_ext;
  logic [WIDTH:0]  p, q;
  logic            q_1;
  logic [WIDTH:0]  p_nxt, q_nxt;
  logic            q_1_nxt;
  logic            accept;
  logic            last_step;

  // Start is honoured from IDLE and from DONE, never while a product is in flight.
  assign accept    = start && (state != CALC);
  assign last_step = (cnt == CW'(WIDTH));

  jbooth_step #(.WIDTH(WIDTH)) u_step (
    .p       (p),
    .q       (q),
    .q_1     (q_1),
    .a_ext   (a_ext),
    .p_nxt   (p_nxt),
    .q_nxt   (q_nxt),
    .q_1_nxt (q_1_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (last_step) state_nxt = DONE;
      DONE:    state_nxt = start ? CALC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

  // Datapath: operand capture, Booth accumulator, step counter and result.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: these are a handful of flops, not a memory, so all of them are cleared on reset.
    if (!rst_n) begin
      a_ext <= '0;
      p     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
      y     <= '0;
    end else if (accept) begin
      // Extension to WIDTH+1 bits lets full-range unsigned operands recode correctly.
      a_ext <= {tc & a[WIDTH-1], a};
      q     <= {tc & b[WIDTH-1], b};
      p     <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
    end else if (state == CALC) begin
      p   <= p_nxt;
      q   <= q_nxt;
      q_1 <= q_1_nxt;
      cnt <= cnt + 1'b1;
      if (last_step) y <= {p_nxt[WIDTH-2:0], q_nxt};
    end
  end

endmodule

// File: tb/tb_jbooth_multiplier.sv
// Self-checking bench for jbooth_multiplier (WIDTH=4): directed, exhaustive and
// handshake scenarios compared against an arithmetic reference product.
module tb_jbooth_multiplier;

  localparam int W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             tc;
  logic [W-1:0]     a, b;
  logic [2*W-1:0]   y;
  logic             busy, done;

  int n_vec  = 0;
  int n_fail = 0;

  jbooth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .tc    (tc),
    .a     (a),
    .b     (b),
    .y     (y),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] z,
                                              input logic t);
    int sx, sz, prod;
    sx   = t ? int'($signed(x)) : int'(x);
    sz   = t ? int'($signed(z)) : int'(z);
    prod = sx * sz;
    return prod[2*W-1:0];
  endfunction

  // Launch one operation, scramble the inputs while busy, and check latency,
  // output stability and the final product.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic t,
                        input string tag);
    logic [2*W-1:0] y_prev;
    int lat;
    start = 1'b1; a = aa; b = bb; tc = t;
    @(posedge clk); #1;
    start  = 1'b0;
    y_prev = y;
    lat    = 0;
    for (int i = 1; i <= 20; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      tc = 1'($urandom);
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
      check({tag, "_y_hold"}, 64'(y), 64'(y_prev));
    end
    check({tag, "_latency"}, 64'(lat), 64'(W + 1));
    check({tag, "_product"}, 64'(y), 64'(ref_prod(aa, bb, t)));
  endtask

  initial begin
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int lat;
    bit saw_done;

    rst_n = 1'b0; start = 1'b0; tc = 1'b0; a = '0; b = '0;
    #1;
    check("reset_y", 64'(y), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Unsigned basics and extremes
    run_op(4'd2, 4'd2, 1'b0, "u2x2");
    run_op(4'd3, 4'd3, 1'b0, "u3x3");
    run_op(4'd3, 4'd4, 1'b0, "u3x4");
    run_op(4'd3, 4'd5, 1'b0, "u3x5");
    run_op(4'd0, 4'd0, 1'b0, "u0x0");
    run_op(4'd1, 4'd1, 1'b0, "u1x1");
    run_op(4'd2, 4'd6, 1'b0, "u2x6");
    run_op(4'd15, 4'd15, 1'b0, "u15x15");
    check("u15x15_const", 64'(y), 64'hE1);
    run_op(4'd3, 4'b1100, 1'b0, "u3x12");
    check("u3x12_const", 64'(y), 64'd36);

    // Signed cases
    run_op(4'd3, 4'b1100, 1'b1, "s3xm4");
    check("s3xm4_const", 64'(y), 64'hF4);
    run_op(4'b1000, 4'b1000, 1'b1, "sm8xm8");
    check("sm8xm8_const", 64'(y), 64'd64);
    run_op(4'b1111, 4'b1111, 1'b1, "sm1xm1");
    check("sm1xm1_const", 64'(y), 64'd1);
    run_op(4'd7, 4'b1000, 1'b1, "s7xm8");
    check("s7xm8_const", 64'(y), 64'hC8);

    // Exhaustive sweep in both modes
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < (1 << W); i++)
        for (int j = 0; j < (1 << W); j++)
          run_op(W'(i), W'(j), 1'(t), "exh");

    // Start held high: products complete back-to-back every W+2 cycles
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      qa.push_back(W'($urandom));
      qb.push_back(W'($urandom));
    end
    tc = 1'b0; start = 1'b1; a = qa[0]; b = qb[0];
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      check("b2b_busy", 64'(busy), 64'd1);
      a = qa[k+1]; b = qb[k+1];
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
        @(posedge clk); #1;
        if (done) begin
          lat = i;
          break;
        end
      end
      check("b2b_latency", 64'(lat), 64'(W + 1));
      check("b2b_product", 64'(y), 64'(ref_prod(qa[k], qb[k], 1'b0)));
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (W + 3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a calculation
    run_op(4'd5, 4'd7, 1'b0, "pre_rst");
    start = 1'b1; a = 4'd9; b = 4'd9; tc = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_y", 64'(y), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (2 * W + 4) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("postrst_idle", 64'(saw_done), 64'd0);
    check("postrst_y", 64'(y), 64'd0);
    run_op(4'd6, 4'd11, 1'b1, "postrst_op");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
